// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the M-stage LSU and the data memory.
// The LSU drives the request side through the master modport; the memory answers
// with read data and a single-cycle completion strobe through the slave modport.
interface mem_stage_lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit. Decodes the instruction in M, issues the data-memory
// access on the req/ack bus, stalls the front of the pipeline while the access is
// outstanding, aborts after TIMEOUT wait cycles, and owns the M->W register.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [31:0]           IR_M,
   input  logic [31:0]           AO_M,
   input  logic [31:0]           V2_M,
   input  logic [4:0]            A3_M,
   input  logic [31:0]           PC4_M,
   mem_stage_lsu_if.master       mem,
   output logic                  Stall_M,
   output logic [31:0]           IR_W,
   output logic [31:0]           AO_W,
   output logic [31:0]           PC4_W,
   output logic [4:0]            A3_W,
   output logic [31:0]           DR_W,
   output logic                  AdE_W,
   output logic                  BusErr_W
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;

   logic        is_load, is_store, is_word, is_half, is_signed;
   logic        aligned, is_mem, go, misalign, abort;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, rdata_sh, ext_data;

   logic        held_we;
   logic [31:0] held_addr, held_wdata;
   logic [3:0]  held_be;

   // Opcode decode, alignment, byte enables and lane-replicated store data.
   // NOTE: every signal assigned in always_comb gets a default first, otherwise
   // a path that skips the assignment infers a latch.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_word   = 1'b0;
      is_half   = 1'b0;
      is_signed = 1'b0;
      unique case (IR_M[31:26])
         6'b100011: begin is_load  = 1'b1; is_word = 1'b1; end                      // lw
         6'b100000: begin is_load  = 1'b1; is_signed = 1'b1; end                    // lb
         6'b100100: begin is_load  = 1'b1; end                                      // lbu
         6'b100001: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end    // lh
         6'b100101: begin is_load  = 1'b1; is_half = 1'b1; end                      // lhu
         6'b101011: begin is_store = 1'b1; is_word = 1'b1; end                      // sw
         6'b101000: begin is_store = 1'b1; end                                      // sb
         6'b101001: begin is_store = 1'b1; is_half = 1'b1; end                      // sh
         default:   ;
      endcase

      is_mem   = is_load | is_store;
      aligned  = is_word ? (AO_M[1:0] == 2'b00) : (is_half ? ~AO_M[0] : 1'b1);
      go       = is_mem & aligned;
      misalign = is_mem & ~aligned;

      if (!is_mem)      be_c = 4'b0000;
      else if (is_word) be_c = 4'b1111;
      else if (is_half) be_c = AO_M[1] ? 4'b1100 : 4'b0011;
      else              be_c = 4'b0001 << AO_M[1:0];

      if (is_word)      wdata_c = V2_M;
      else if (is_half) wdata_c = {2{V2_M[15:0]}};
      else              wdata_c = {4{V2_M[7:0]}};
   end

   // Load lane selection and sign/zero extension of the returned word.
   always_comb begin
      rdata_sh = mem.mem_rdata >> {AO_M[1:0], 3'b000};
      if (is_word)      ext_data = mem.mem_rdata;
      else if (is_half) ext_data = {{16{is_signed & rdata_sh[15]}}, rdata_sh[15:0]};
      else              ext_data = {{24{is_signed & rdata_sh[7]}}, rdata_sh[7:0]};
   end

   // FSM state register and wait-cycle counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // FSM next-state: enter WAIT when the first cycle goes unacknowledged,
   // leave on ack (which beats a simultaneous timeout) or on abort.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE: begin
            if (go && !mem.mem_ack) begin
               state_nx = S_WAIT;
               cnt_nx   = CNT_W'(1);
            end else begin
               cnt_nx   = '0;
            end
         end
         S_WAIT: begin
            if (mem.mem_ack || abort) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // FSM outputs: request straight from decode in IDLE, from the held copy in WAIT.
   always_comb begin
      abort         = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = is_store;
      mem.mem_addr  = {AO_M[31:2], 2'b00};
      mem.mem_be    = be_c;
      mem.mem_wdata = wdata_c;
      unique case (state)
         S_IDLE: mem.mem_req = go;
         S_WAIT: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = held_we;
            mem.mem_addr  = held_addr;
            mem.mem_be    = held_be;
            mem.mem_wdata = held_wdata;
            abort         = !mem.mem_ack && (cnt == CNT_W'(TIMEOUT));
         end
         default: ;
      endcase
      Stall_M = mem.mem_req & ~mem.mem_ack & ~abort;
   end

   // Capture the bus request issued in IDLE so it stays frozen through WAIT.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         held_we    <= 1'b0;
         held_addr  <= '0;
         held_be    <= '0;
         held_wdata <= '0;
      end else if (state == S_IDLE) begin
         held_we    <= is_store;
         held_addr  <= {AO_M[31:2], 2'b00};
         held_be    <= be_c;
         held_wdata <= wdata_c;
      end
   end

   // M->W pipeline register: bubble while stalled, otherwise advance the
   // instruction with its load data and exception flags.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         IR_W     <= '0;
         AO_W     <= '0;
         PC4_W    <= RESET_PC;
         A3_W     <= '0;
         DR_W     <= '0;
         AdE_W    <= 1'b0;
         BusErr_W <= 1'b0;
      end else if (Stall_M) begin
         IR_W     <= '0;
         AO_W     <= '0;
         A3_W     <= '0;
         DR_W     <= '0;
         AdE_W    <= 1'b0;
         BusErr_W <= 1'b0;
      end else begin
         IR_W     <= IR_M;
         AO_W     <= AO_M;
         PC4_W    <= PC4_M;
         A3_W     <= (misalign || abort) ? 5'd0 : A3_M;
         DR_W     <= (is_load && aligned && !abort) ? ext_data : 32'd0;
         AdE_W    <= misalign;
         BusErr_W <= abort;
      end
   end

endmodule
